lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly downstream of the execute-stage ALU. It takes the ALU `result` as the effective address for RV32I loads and stores, plus rs2 as store data. It runs a request/grant/response handshake against the data-memory port and returns aligned, sign- or zero-extended load data to writeback. While a memory access is in flight it stalls the pipeline.

## Interface
- `XLEN`, 32: data/address width (matches `RegBus`).
- `clk` in 1: core clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX stage presents a memory op this cycle.
- `ex_load` in 1: op is a load. `ex_store` in 1: op is a store. The two are never both 1.
- `ex_funct3` in 3: RV32I width/sign field.
- `ex_addr` in XLEN: effective address (ALU result).
- `ex_wdata` in XLEN: store data (rs2).
- `ex_rd` in 5: load destination register.
- `lsu_ready` out 1: unit can accept an op this cycle.
- `lsu_stall` out 1: the pipeline must hold EX.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out XLEN (word-aligned), `mem_be` out 4, `mem_wdata` out XLEN: data-memory request.
- `mem_gnt` in 1: request accepted. `mem_rvalid` in 1: read data valid. `mem_rdata` in XLEN: read data.
- `wb_valid` out 1, `wb_rd` out 5, `wb_data` out XLEN: load writeback.
- `lsu_err` out 1: one-cycle pulse for a misaligned access or illegal funct3.

## Operation
- States:
  - IDLE: no access in progress.
  - REQ: `mem_req` held, waiting for `mem_gnt`.
  - RESP: load granted, waiting for `mem_rvalid`.
- Accept condition: `ex_valid & (ex_load | ex_store) & lsu_ready`. `lsu_ready` = (state == IDLE).
- On accept, the op is checked before any memory request is issued:
  - Misaligned: LH/LHU/SH with `addr[0]` = 1, or LW/SW with `addr[1:0]` ≠ 0.
  - Illegal funct3: loads other than 000/001/010/100/101, stores other than 000/001/010.
  - Either case: `lsu_err` = 1 next cycle, no memory request, state stays IDLE, `wb_valid` stays 0.
- Otherwise on accept: register address, be, wdata, rd and load-type, then go IDLE → REQ.
- Request encoding:
  - `mem_addr` = {addr[XLEN-1:2], 2'b00}.
  - SB: `mem_be` = 4'b0001 << addr[1:0]; store byte replicated on all 4 lanes.
  - SH: `mem_be` = 4'b0011 << addr[1:0]; store half replicated on both halves.
  - SW: `mem_be` = 4'b1111.
  - Loads: `mem_be` = 4'b1111, `mem_we` = 0.
- REQ: all `mem_*` outputs stay stable until `mem_gnt`. On gnt, a store goes to IDLE (complete) and a load goes to RESP. `mem_rvalid` is ignored in REQ.
- RESP: on `mem_rvalid`, extract byte/half at addr[1:0] and sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes through. Register the result to `wb_data`, pulse `wb_valid`, return to IDLE.
- `lsu_stall` = `ex_valid & (ex_load | ex_store) & ~lsu_ready`, OR'd with (state ≠ IDLE).
- A `mem_rvalid` arriving in IDLE (e.g. a stale response after reset) is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; `lsu_ready` = 1.
- Asserting `rst_n` mid-access drops `mem_req` immediately (asynchronous) and returns the unit to IDLE.
- Store latency: accept at cycle N, `mem_req` high at N+1; with gnt at N+1, IDLE and ready at N+2.
- Load latency: accept at N, req at N+1, gnt at N+1, rvalid at N+2, `wb_valid` at N+3. Zero-wait load = 3 cycles accept-to-writeback.
- `lsu_ready` is 1 in the same cycle `wb_valid` is 1, so back-to-back ops are allowed with no bubble beyond the handshake.
- `lsu_err` is a 1-cycle pulse at N+1. The next op may be accepted at N+1.

## Structure
- Add to `defines.v`: funct3 codes `LSU_LB`/`LH`/`LW`/`LBU`/`LHU`/`SB`/`SH`/`SW`, and state encodings `LSU_IDLE`/`LSU_REQ`/`LSU_RESP`.
- Sub-module `lsu_align` (combinational): store be/data lane steering, load extract/extend, misalign/illegal detect. Instantiated once; the FSM and registers live in `lsu`.

## Test plan
- SB at addr 0x103, wdata 0x000000A5, gnt immediately → `mem_addr` 0x100, `mem_be` 4'b1000, `mem_wdata` 0xA5A5A5A5, `mem_we` 1; ready again 2 cycles after accept.
- LB at 0x202, rdata 0x00800000 → `wb_data` 0xFFFFFF80. LBU at same address and rdata → 0x00000080. `wb_valid` 3 cycles after accept.
- LH at 0x301 → `lsu_err` pulse, `mem_req` never asserts, `wb_valid` 0. SW at 0x302 → same behaviour.
- LW at 0x400 with gnt delayed 4 cycles and rvalid 2 cycles later:
  - `mem_*` outputs stable throughout the wait.
  - `lsu_stall` held until `wb_valid`.
  - `wb_data` = rdata 0x12345678, `wb_rd` = `ex_rd`.
- `rst_n` low while in RESP, then an rvalid arrives after reset → no `wb_valid`, state IDLE, all outputs 0.
- Back-to-back LW, SW, LHU (0x502, rdata 0xBEEF0000 → 0x0000BEEF) → each accepted in the cycle `lsu_ready` returns; exactly one `wb_valid` per load.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width/sign codes and FSM states.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/data steering, access checks,
// and load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            req_load,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [1:0]      req_offset,
  input  logic [XLEN-1:0] req_wdata,
  output logic [3:0]      req_be,
  output logic [XLEN-1:0] req_lane_wdata,
  output logic            req_misaligned,
  output logic            req_illegal,
  input  logic [2:0]      rsp_funct3,
  input  logic [1:0]      rsp_offset,
  input  logic [XLEN-1:0] rsp_rdata,
  output logic [XLEN-1:0] rsp_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    req_be         = 4'b1111;
    req_lane_wdata = req_wdata;
    req_misaligned = 1'b0;
    req_illegal    = 1'b0;
    if (req_store) begin
      case (req_funct3)
        LSU_SB: begin
          req_be         = 4'b0001 << req_offset;
          req_lane_wdata = {4{req_wdata[7:0]}};
        end
        LSU_SH: begin
          req_be         = 4'b0011 << req_offset;
          req_lane_wdata = {2{req_wdata[15:0]}};
          req_misaligned = req_offset[0];
        end
        LSU_SW:  req_misaligned = |req_offset;
        default: req_illegal = 1'b1;
      endcase
    end else if (req_load) begin
      case (req_funct3)
        LSU_LB, LSU_LBU: req_misaligned = 1'b0;
        LSU_LH, LSU_LHU: req_misaligned = req_offset[0];
        LSU_LW:          req_misaligned = |req_offset;
        default:         req_illegal = 1'b1;
      endcase
    end
  end

  // Move the addressed byte/half down to bit 0 before extending.
  assign shifted = rsp_rdata >> {rsp_offset, 3'b000};

  always_comb begin
    rsp_data = shifted;
    case (rsp_funct3)
      LSU_LB:  rsp_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LSU_LH:  rsp_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LSU_LBU: rsp_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LSU_LHU: rsp_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: rsp_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts EX-stage memory ops, runs the req/gnt/rvalid
// handshake with data memory, and returns extended load data to writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_load,
  input  logic            ex_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [4:0]      ex_rd,
  output logic            lsu_ready,
  output logic            lsu_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            lsu_err
);

  lsu_state_e      state_reg, state_next;
  logic [XLEN-1:0] addr_reg;
  logic [1:0]      offset_reg;
  logic [3:0]      be_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            we_reg;
  logic [2:0]      funct3_reg;
  logic [4:0]      rd_reg;
  logic            wb_valid_reg;
  logic [4:0]      wb_rd_reg;
  logic [XLEN-1:0] wb_data_reg;
  logic            err_reg;

  logic [3:0]      req_be;
  logic [XLEN-1:0] req_lane_wdata;
  logic            req_misaligned;
  logic            req_illegal;
  logic [XLEN-1:0] rsp_data;
  logic            mem_op;
  logic            accept;
  logic            bad_op;

  lsu_align #(.XLEN(XLEN)) u_align (
    .req_load       (ex_load),
    .req_store      (ex_store),
    .req_funct3     (ex_funct3),
    .req_offset     (ex_addr[1:0]),
    .req_wdata      (ex_wdata),
    .req_be         (req_be),
    .req_lane_wdata (req_lane_wdata),
    .req_misaligned (req_misaligned),
    .req_illegal    (req_illegal),
    .rsp_funct3     (funct3_reg),
    .rsp_offset     (offset_reg),
    .rsp_rdata      (mem_rdata),
    .rsp_data       (rsp_data)
  );

  assign mem_op    = ex_valid & (ex_load | ex_store);
  assign lsu_ready = (state_reg == LSU_IDLE);
  assign accept    = mem_op & lsu_ready;
  assign bad_op    = req_misaligned | req_illegal;
  assign lsu_stall = (mem_op & ~lsu_ready) | (state_reg != LSU_IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LSU_IDLE: if (accept && !bad_op) state_next = LSU_REQ;
      LSU_REQ:  if (mem_gnt) state_next = we_reg ? LSU_IDLE : LSU_RESP;
      LSU_RESP: if (mem_rvalid) state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= LSU_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      offset_reg   <= '0;
      be_reg       <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      funct3_reg   <= '0;
      rd_reg       <= '0;
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      err_reg      <= accept & bad_op;
      wb_valid_reg <= 1'b0;
      if (accept && !bad_op) begin
        addr_reg   <= {ex_addr[XLEN-1:2], 2'b00};
        offset_reg <= ex_addr[1:0];
        be_reg     <= req_be;
        wdata_reg  <= req_lane_wdata;
        we_reg     <= ex_store;
        funct3_reg <= ex_funct3;
        rd_reg     <= ex_rd;
      end
      if (state_reg == LSU_RESP && mem_rvalid) begin
        wb_valid_reg <= 1'b1;
        wb_rd_reg    <= rd_reg;
        wb_data_reg  <= rsp_data;
      end
    end
  end

  // Request fields are only driven while a request is outstanding, so an
  // asynchronous reset clears the whole memory port at once.
  assign mem_req   = (state_reg == LSU_REQ);
  assign mem_we    = mem_req & we_reg;
  assign mem_addr  = mem_req ? addr_reg  : '0;
  assign mem_be    = mem_req ? be_reg    : '0;
  assign mem_wdata = mem_req ? wdata_reg : '0;

  assign wb_valid = wb_valid_reg;
  assign wb_rd    = wb_rd_reg;
  assign wb_data  = wb_data_reg;
  assign lsu_err  = err_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: drives and samples on the falling clock edge.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        lsu_ready, lsu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_err;

  int checks = 0;
  int passed = 0;
  int wb_count = 0;
  int cnt0;

  always #5 clk = ~clk;

  lsu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_ready(lsu_ready), .lsu_stall(lsu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_err(lsu_err)
  );

  always @(posedge clk) if (wb_valid) wb_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
  endtask

  // Zero-wait load: gnt in the first request cycle, rvalid one cycle later.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] exp);
    step(); issue(1'b1, 1'b0, f3, addr, 32'h0, rd);
    step(); clear_ex();
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_be"}, 32'(mem_be), 32'hF);
    check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0;
    check({tag, "_resp_req"}, 32'(mem_req), 32'd0);
    check({tag, "_resp_stall"}, 32'(lsu_stall), 32'd1);
    check({tag, "_resp_wbv"}, 32'(wb_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step(); mem_rvalid = 1'b0;
    check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    check({tag, "_wbdata"}, wb_data, exp);
    check({tag, "_wbrd"}, 32'(wb_rd), 32'(rd));
    check({tag, "_ready"}, 32'(lsu_ready), 32'd1);
    step();
    check({tag, "_wbv_pulse"}, 32'(wb_valid), 32'd0);
  endtask

  task automatic do_err(input string tag, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] addr);
    step(); issue(ld, st, f3, addr, 32'h55, 5'd7);
    step(); clear_ex();
    check({tag, "_err"}, 32'(lsu_err), 32'd1);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_ready"}, 32'(lsu_ready), 32'd1);
    step();
    check({tag, "_err_pulse"}, 32'(lsu_err), 32'd0);
    check({tag, "_req2"}, 32'(mem_req), 32'd0);
    check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_ready", 32'(lsu_ready), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(lsu_stall), 32'd0);
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_err", 32'(lsu_err), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    rst_n = 1'b1;

    // SB 0x103: byte lane 3, data replicated
    step(); issue(1'b0, 1'b1, LSU_SB, 32'h103, 32'h0000_00A5, 5'd0);
    step(); clear_ex();
    check("sb_req", 32'(mem_req), 32'd1);
    check("sb_we", 32'(mem_we), 32'd1);
    check("sb_addr", mem_addr, 32'h100);
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_stall", 32'(lsu_stall), 32'd1);
    check("sb_busy", 32'(lsu_ready), 32'd0);
    mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0;
    check("sb_ready", 32'(lsu_ready), 32'd1);
    check("sb_req_done", 32'(mem_req), 32'd0);

    do_load("lb", LSU_LB, 32'h202, 32'h0080_0000, 5'd4, 32'hFFFF_FF80);
    do_load("lbu", LSU_LBU, 32'h202, 32'h0080_0000, 5'd5, 32'h0000_0080);
    do_load("lh_hi", LSU_LH, 32'h206, 32'h8001_1234, 5'd6, 32'hFFFF_8001);

    do_err("lh_mis", 1'b1, 1'b0, LSU_LH, 32'h301);
    do_err("sw_mis", 1'b0, 1'b1, LSU_SW, 32'h302);
    do_err("ld_ill", 1'b1, 1'b0, 3'b011, 32'h700);
    do_err("st_ill", 1'b0, 1'b1, 3'b100, 32'h704);

    // LW with gnt delayed 4 cycles, a stray rvalid during REQ, rvalid 2 cycles after gnt
    step(); issue(1'b1, 1'b0, LSU_LW, 32'h400, 32'h0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      step(); clear_ex();
      check("lwd_req", 32'(mem_req), 32'd1);
      check("lwd_addr", mem_addr, 32'h400);
      check("lwd_be", 32'(mem_be), 32'hF);
      check("lwd_we", 32'(mem_we), 32'd0);
      check("lwd_stall", 32'(lsu_stall), 32'd1);
      mem_rvalid = (i == 1);
      mem_rdata = (i == 1) ? 32'hDEAD_DEAD : 32'h0;
    end
    step(); mem_rvalid = 1'b0;
    check("lwd_req_last", 32'(mem_req), 32'd1);
    check("lwd_wbv_early", 32'(wb_valid), 32'd0);
    mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0;
    check("lwd_resp_req", 32'(mem_req), 32'd0);
    check("lwd_resp_stall", 32'(lsu_stall), 32'd1);
    step();
    check("lwd_resp_stall2", 32'(lsu_stall), 32'd1);
    check("lwd_wbv_wait", 32'(wb_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step(); mem_rvalid = 1'b0;
    check("lwd_wbv", 32'(wb_valid), 32'd1);
    check("lwd_wbdata", wb_data, 32'h1234_5678);
    check("lwd_wbrd", 32'(wb_rd), 32'd9);
    check("lwd_stall_end", 32'(lsu_stall), 32'd0);

    // Reset while in RESP, stale rvalid afterwards
    step(); issue(1'b1, 1'b0, LSU_LW, 32'h600, 32'h0, 5'd3);
    step(); clear_ex(); mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0;
    check("rr_stall", 32'(lsu_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_req", 32'(mem_req), 32'd0);
    check("rr_stall_rst", 32'(lsu_stall), 32'd0);
    check("rr_ready", 32'(lsu_ready), 32'd1);
    step(); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step(); mem_rvalid = 1'b0;
    check("rr_wbv", 32'(wb_valid), 32'd0);
    check("rr_wbdata", wb_data, 32'h0);
    check("rr_wbrd", 32'(wb_rd), 32'd0);
    check("rr_idle", 32'(lsu_ready), 32'd1);
    check("rr_addr", mem_addr, 32'h0);
    check("rr_err", 32'(lsu_err), 32'd0);

    // Back-to-back LW, SW, LHU
    cnt0 = wb_count;
    step(); issue(1'b1, 1'b0, LSU_LW, 32'h500, 32'h0, 5'd1);
    step(); clear_ex();
    check("bb_lw_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step(); mem_rvalid = 1'b0;
    check("bb_lw_wbv", 32'(wb_valid), 32'd1);
    check("bb_lw_data", wb_data, 32'hCAFE_F00D);
    check("bb_lw_ready", 32'(lsu_ready), 32'd1);
    issue(1'b0, 1'b1, LSU_SW, 32'h504, 32'h1122_3344, 5'd0);
    check("bb_sw_nostall", 32'(lsu_stall), 32'd0);
    step(); clear_ex();
    check("bb_sw_req", 32'(mem_req), 32'd1);
    check("bb_sw_we", 32'(mem_we), 32'd1);
    check("bb_sw_addr", mem_addr, 32'h504);
    check("bb_sw_be", 32'(mem_be), 32'hF);
    check("bb_sw_wdata", mem_wdata, 32'h1122_3344);
    check("bb_sw_wbv", 32'(wb_valid), 32'd0);
    mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0;
    check("bb_sw_ready", 32'(lsu_ready), 32'd1);
    issue(1'b1, 1'b0, LSU_LHU, 32'h502, 32'h0, 5'd2);
    step(); clear_ex();
    check("bb_lhu_req", 32'(mem_req), 32'd1);
    check("bb_lhu_addr", mem_addr, 32'h500);
    mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
    step(); mem_rvalid = 1'b0;
    check("bb_lhu_wbv", 32'(wb_valid), 32'd1);
    check("bb_lhu_data", wb_data, 32'h0000_BEEF);
    check("bb_lhu_rd", 32'(wb_rd), 32'd2);
    step();
    check("bb_wb_count", 32'(wb_count - cnt0), 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
